// File: rtl/fpga_arb_pkg.sv
// fpga_arb_pkg: shared types for the FIFO write-port arbiter.
package fpga_arb_pkg;
   typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: find-first-set over req starting at ptr, wrapping N-1 -> 0.
module rr_priority_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 any,
   output logic [$clog2(N)-1:0] idx
);
   localparam int W = $clog2(N);
   logic [W-1:0] j;
   // Scan from the farthest offset down so the nearest set bit after ptr wins.
   always_comb begin
      any = |req;
      idx = ptr;
      j = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = W'((int'(ptr) + k) % N);
         if (req[j]) idx = j;
      end
   end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of one FIFO write port among N_REQ
// producers, with grants bounded to MAX_BURST words.
module fifo_write_arbiter
   import fpga_arb_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [WIDTH-1:0]         req_data [N_REQ],
   output logic [N_REQ-1:0]         req_ready,
   input  logic                     fifo_full,
   output logic                     fifo_we,
   output logic [WIDTH-1:0]         fifo_data,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     busy
);
   localparam int W  = $clog2(N_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);
   arb_state_t    state;
   logic [W-1:0]  rr_ptr, win, nxt_ptr;
   logic [CW-1:0] burst_cnt;
   logic          any, vld_g, xfer, last;
   rr_priority_picker #(.N(N_REQ)) u_pick (
      .req (req_valid),
      .ptr (rr_ptr),
      .any (any),
      .idx (win)
   );
   assign busy      = state == ARB_BURST;
   assign vld_g     = req_valid[grant_id];
   assign xfer      = busy && vld_g && !fifo_full;
   assign last      = xfer && burst_cnt == CW'(MAX_BURST - 1);
   assign nxt_ptr   = (grant_id == W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
   assign req_ready = (busy && !fifo_full) ? N_REQ'(1) << grant_id : '0;
   assign fifo_we   = xfer;
   assign fifo_data = busy ? req_data[grant_id] : '0;
   // A full FIFO freezes the burst: no count, no exit, grant kept.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ARB_IDLE;
         rr_ptr    <= '0;
         grant_id  <= '0;
         burst_cnt <= '0;
      end else if (state == ARB_IDLE) begin
         if (any) begin
            grant_id  <= win;
            burst_cnt <= '0;
            state     <= ARB_BURST;
         end
      end else if (last || !vld_g) begin
         state  <= ARB_IDLE;
         rr_ptr <= nxt_ptr;
      end else if (xfer) begin
         burst_cnt <= burst_cnt + 1'b1;
      end
   end
endmodule
